// File: rtl/icache_fetcher_pkg.sv
// Shared definitions for the instruction fetcher: widths, reset PC default,
// FSM state encodings and the sequential-PC helper.
package icache_fetcher_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Fetch FSM encodings, kept as plain constants for older tools
  localparam logic [1:0] ST_LOOKUP = 2'd0;
  localparam logic [1:0] ST_REQ    = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;

  // Sequential fetch address; wraps naturally at 2^32
  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/icache_fetcher_array.sv
// Direct-mapped, one-word-per-line storage for the fetcher: valid/tag/data,
// combinational read by index and a single write port. Only the valid bits
// are reset; tag and data contents are meaningless until their line is valid.
module icache_fetcher_array
  import icache_fetcher_pkg::*;
#(
  parameter int LINES = 64,
  parameter int IDX_W = 6,
  parameter int TAG_W = 24
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [INSTR_W-1:0] rd_data,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [INSTR_W-1:0] wr_data
);

  logic [LINES-1:0]   valid;
  logic [TAG_W-1:0]   tag_mem  [LINES];
  logic [INSTR_W-1:0] data_mem [LINES];

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[rd_idx];

  // Valid bits: cleared by reset, set when a refill lands in the line
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // Tag and data payload: unconditional overwrite of the indexed line
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/icache_fetcher.sv
// Instruction fetcher: owns the fetch PC, looks it up in a small direct-mapped
// cache and pushes one instruction per cycle into the IF queue while it has
// room. Misses issue a single word read to mem_ctrl and re-look-up after the
// refill. A ROB redirect reloads the PC at once; an in-flight refill is left to
// complete into the cache but its word is never pushed.
module icache_fetcher
  import icache_fetcher_pkg::*;
#(
  parameter int              ICACHE_LINES = 64,
  parameter logic [XLEN-1:0] RESET_PC     = RESET_PC_DEFAULT
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               rdy_in,
  input  logic               if_not_full_in,
  input  logic               rob_jump_in,
  input  logic [XLEN-1:0]    rob_jump_pc_in,
  output logic               mem_req_valid,
  output logic [XLEN-1:0]    mem_req_addr,
  input  logic               mem_req_ready,
  input  logic               mem_resp_valid,
  input  logic [INSTR_W-1:0] mem_resp_data,
  output logic               icache_have_input,
  output logic [INSTR_W-1:0] icache_instr,
  output logic [XLEN-1:0]    icache_instr_pc
);

  localparam int IDX   = $clog2(ICACHE_LINES);
  localparam int TAG_W = XLEN - IDX - 2;

  logic [1:0]         state;
  logic [XLEN-1:0]    pc;
  logic [XLEN-1:0]    miss_addr;
  logic [XLEN-1:0]    jump_pc;
  logic               rd_valid;
  logic [TAG_W-1:0]   rd_tag;
  logic [INSTR_W-1:0] rd_data;
  logic               hit;
  logic               fill_en;

  // Redirect targets are forced word aligned so pc[1:0] stays 00
  assign jump_pc = rob_jump_pc_in & ~32'h3;

  assign hit     = rd_valid && (rd_tag == pc[XLEN-1:IDX+2]);
  assign fill_en = rdy_in && (state == ST_WAIT) && mem_resp_valid;

  // miss_addr is frozen from the miss until the next miss, so it doubles as
  // the stable request address
  assign mem_req_addr = miss_addr;

  icache_fetcher_array #(
    .LINES (ICACHE_LINES),
    .IDX_W (IDX),
    .TAG_W (TAG_W)
  ) u_array (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .rd_idx   (pc[IDX+1:2]),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (fill_en),
    .wr_idx   (miss_addr[IDX+1:2]),
    .wr_tag   (miss_addr[XLEN-1:IDX+2]),
    .wr_data  (mem_resp_data)
  );

  // Fetch FSM, PC and registered push/request outputs; rdy_in low freezes all of it
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state             <= ST_LOOKUP;
      pc                <= RESET_PC;
      miss_addr         <= '0;
      mem_req_valid     <= 1'b0;
      icache_have_input <= 1'b0;
      icache_instr      <= '0;
      icache_instr_pc   <= '0;
    end else if (rdy_in) begin
      icache_have_input <= 1'b0;
      case (state)
        ST_LOOKUP: begin
          if (rob_jump_in) begin
            pc <= jump_pc;
          end else if (hit) begin
            if (if_not_full_in) begin
              icache_have_input <= 1'b1;
              icache_instr      <= rd_data;
              icache_instr_pc   <= pc;
              pc                <= next_pc(pc);
            end
          end else begin
            miss_addr     <= pc;
            mem_req_valid <= 1'b1;
            state         <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (rob_jump_in) begin
            pc <= jump_pc;
          end
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (rob_jump_in) begin
            pc <= jump_pc;
          end
          if (mem_resp_valid) begin
            state <= ST_LOOKUP;
          end
        end
        default: begin
          mem_req_valid <= 1'b0;
          state         <= ST_LOOKUP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_fetcher.sv
// Self-checking bench for icache_fetcher: a memory responder with fixed
// latency, a scoreboard of expected pushes drained by an output monitor, and
// directed scenarios for cold start, warm streaming, backpressure, redirects,
// index conflicts, rdy_in freezing and asynchronous reset.
module tb_icache_fetcher;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } push_t;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        rdy_in;
  logic        if_not_full_in;
  logic        rob_jump_in;
  logic [31:0] rob_jump_pc_in;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data  = 32'h0;
  logic        icache_have_input;
  logic [31:0] icache_instr;
  logic [31:0] icache_instr_pc;

  int          testsRun    = 0;
  int          testsFailed = 0;
  int          cycle       = 0;
  int          pushCount   = 0;
  logic        reqSeen     = 1'b0;
  push_t       expQ[$];
  int          pushCycles[$];
  logic [31:0] reqLog[$];

  logic [31:0] pendAddr      = 32'h0;
  int          pendCnt       = 0;
  int          respDelay     = 2;
  logic        respNextValid = 1'b0;
  logic [31:0] respNextData  = 32'h0;

  icache_fetcher #(
    .ICACHE_LINES (64),
    .RESET_PC     (32'h0)
  ) dut (
    .clk_in            (clk_in),
    .rst_n_in          (rst_n_in),
    .rdy_in            (rdy_in),
    .if_not_full_in    (if_not_full_in),
    .rob_jump_in       (rob_jump_in),
    .rob_jump_pc_in    (rob_jump_pc_in),
    .mem_req_valid     (mem_req_valid),
    .mem_req_addr      (mem_req_addr),
    .mem_req_ready     (mem_req_ready),
    .mem_resp_valid    (mem_resp_valid),
    .mem_resp_data     (mem_resp_data),
    .icache_have_input (icache_have_input),
    .icache_instr      (icache_instr),
    .icache_instr_pc   (icache_instr_pc)
  );

  always #5 clk_in = ~clk_in;

  // Memory image: address 0 holds a NOP, everything else a PC-derived pattern
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a == 32'h0) ? 32'h0000_0013 : (a ^ 32'h5A5A_0013);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic expectPush(input logic [31:0] pc);
    push_t e;
    e.pc    = pc;
    e.instr = memWord(pc);
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic notFull, input logic jump, input logic [31:0] jumpPc);
    if_not_full_in = notFull;
    rob_jump_in    = jump;
    rob_jump_pc_in = jumpPc;
  endtask

  task automatic redirectTo(input logic [31:0] target, input logic notFull);
    applyStimulus(notFull, 1'b1, target);
    @(negedge clk_in);
    applyStimulus(notFull, 1'b0, 32'h0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic waitPushes(input string tag, input int left, input int budget);
    int n = 0;
    while (expQ.size() > left && n < budget) begin
      @(negedge clk_in);
      n++;
    end
    checkOutput(tag, 32'(expQ.size()), 32'(left));
    if (expQ.size() > left) expQ.delete();
    if (left == 0) if_not_full_in = 1'b0;
  endtask

  task automatic waitHandshake(input int prevSize, input int budget);
    int n = 0;
    while (reqLog.size() <= prevSize && n < budget) begin
      @(negedge clk_in);
      n++;
    end
    checkOutput("handshake seen", 32'(reqLog.size() > prevSize), 32'd1);
  endtask

  always @(posedge clk_in) cycle++;

  // Output monitor: samples just after the edge and drains the scoreboard
  always @(posedge clk_in) begin : monitor
    logic  rdyAtEdge;
    push_t e;
    rdyAtEdge = rdy_in;
    #1;
    if (rst_n_in) begin
      if (mem_req_valid) reqSeen = 1'b1;
      if (rdyAtEdge && icache_have_input) begin
        pushCount++;
        pushCycles.push_back(cycle);
        checkOutput("push expected", 32'(expQ.size() != 0), 32'd1);
        if (expQ.size() != 0) begin
          e = expQ.pop_front();
          checkOutput("push pc", icache_instr_pc, e.pc);
          checkOutput("push instr", icache_instr, e.instr);
        end
      end
    end
  end

  // Memory responder: logs handshakes, answers after respDelay active cycles,
  // holds the response until an rdy_in cycle consumes it
  always @(posedge clk_in) begin
    if (!rst_n_in) begin
      pendCnt       = 0;
      respNextValid = 1'b0;
    end else if (rdy_in) begin
      if (mem_resp_valid) respNextValid = 1'b0;
      if (pendCnt > 0) begin
        pendCnt--;
        if (pendCnt == 0) begin
          respNextValid = 1'b1;
          respNextData  = memWord(pendAddr);
        end
      end
      if (mem_req_valid && mem_req_ready) begin
        reqLog.push_back(mem_req_addr);
        pendAddr = mem_req_addr;
        pendCnt  = respDelay;
      end
    end
  end

  // Drive the response bus away from the active edge
  always @(negedge clk_in) begin
    mem_resp_valid = rst_n_in ? respNextValid : 1'b0;
    mem_resp_data  = respNextData;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int sz;
    int start;
    int t0;
    int latA;
    int latB;

    rst_n_in      = 1'b0;
    rdy_in        = 1'b1;
    mem_req_ready = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0);
    idle(2);

    // Reset state
    checkOutput("reset have_input", 32'(icache_have_input), 32'd0);
    checkOutput("reset req_valid", 32'(mem_req_valid), 32'd0);
    checkOutput("reset req_addr", mem_req_addr, 32'h0);
    checkOutput("reset instr", icache_instr, 32'h0);
    checkOutput("reset instr_pc", icache_instr_pc, 32'h0);
    rst_n_in = 1'b1;

    // Cold start
    expectPush(32'h0);
    if_not_full_in = 1'b1;
    waitPushes("cold push drained", 0, 40);
    idle(10);
    checkOutput("cold req count", 32'(reqLog.size()), 32'd2);
    checkOutput("cold first req", reqLog[0], 32'h0);
    checkOutput("cold next req", reqLog[1], 32'h4);

    // Fill the rest of the warm loop
    for (int a = 4; a <= 12; a += 4) expectPush(32'(a));
    if_not_full_in = 1'b1;
    waitPushes("preload drained", 0, 80);
    idle(10);

    // Warm loop: all hits, consecutive pushes, no memory traffic
    for (int a = 0; a <= 12; a += 4) expectPush(32'(a));
    pushCycles.delete();
    reqSeen = 1'b0;
    sz = reqLog.size();
    redirectTo(32'h0, 1'b1);
    waitPushes("warm drained", 0, 20);
    checkOutput("warm consecutive", 32'(pushCycles[3] - pushCycles[0]), 32'd3);
    checkOutput("warm no req_valid", 32'(reqSeen), 32'd0);
    checkOutput("warm req count", 32'(reqLog.size()), 32'(sz));

    // Backpressure mid-stream
    for (int a = 0; a <= 16; a += 4) expectPush(32'(a));
    redirectTo(32'h0, 1'b1);
    waitPushes("bp first half", 3, 20);
    if_not_full_in = 1'b0;
    start = pushCount;
    idle(5);
    checkOutput("bp stalled pushes", 32'(pushCount - start), 32'd0);
    pushCycles.delete();
    if_not_full_in = 1'b1;
    waitPushes("bp resume drained", 0, 20);
    checkOutput("bp resume consecutive", 32'(pushCycles[2] - pushCycles[0]), 32'd2);
    idle(10);

    // Redirect while waiting on a refill of 0x40
    sz = reqLog.size();
    redirectTo(32'h40, 1'b1);
    waitHandshake(sz, 20);
    checkOutput("wait req addr", reqLog[sz], 32'h40);
    expectPush(32'h100);
    redirectTo(32'h100, 1'b1);
    waitPushes("redirect push drained", 0, 40);
    idle(10);
    sz = reqLog.size();
    expectPush(32'h40);
    redirectTo(32'h40, 1'b1);
    waitPushes("refilled 0x40 drained", 0, 20);
    checkOutput("0x40 hit no req", 32'(reqLog.size()), 32'(sz));
    idle(10);

    // Conflict: line 0 now holds 0x100, so 0x0 must be refetched
    sz = reqLog.size();
    expectPush(32'h0);
    t0 = cycle;
    redirectTo(32'h0, 1'b1);
    waitPushes("conflict push drained", 0, 40);
    latA = pushCycles[$] - t0;
    checkOutput("conflict refetch addr", reqLog[sz], 32'h0);
    idle(10);
    expectPush(32'h100);
    redirectTo(32'h100, 1'b1);
    waitPushes("evict push drained", 0, 40);
    idle(10);

    // Same refetch with rdy_in low for 3 cycles mid-refill
    sz = reqLog.size();
    expectPush(32'h0);
    t0 = cycle;
    redirectTo(32'h0, 1'b1);
    waitHandshake(sz, 20);
    rdy_in = 1'b0;
    idle(3);
    rdy_in = 1'b1;
    waitPushes("stall push drained", 0, 40);
    latB = pushCycles[$] - t0;
    checkOutput("rdy stall shift", 32'(latB - latA), 32'd3);
    idle(10);

    // Asynchronous reset while a refill is outstanding
    sz = reqLog.size();
    redirectTo(32'h200, 1'b1);
    waitHandshake(sz, 20);
    #2;
    rst_n_in = 1'b0;
    #1;
    checkOutput("async rst have_input", 32'(icache_have_input), 32'd0);
    checkOutput("async rst req_valid", 32'(mem_req_valid), 32'd0);
    checkOutput("async rst req_addr", mem_req_addr, 32'h0);
    checkOutput("async rst instr", icache_instr, 32'h0);
    checkOutput("async rst instr_pc", icache_instr_pc, 32'h0);
    @(negedge clk_in);
    applyStimulus(1'b1, 1'b0, 32'h0);
    rst_n_in = 1'b1;
    sz = reqLog.size();
    expectPush(32'h0);
    waitPushes("post reset push drained", 0, 40);
    checkOutput("post reset req", reqLog[sz], 32'h0);
    idle(10);
    checkOutput("post reset next req", reqLog[sz+1], 32'h4);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
